// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Read misses refill a whole line word by word; stores always go through to memory.
module dcache_ctrl #(
  parameter int NUM_LINES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_addr;
  logic [31:0]        r_wdata;
  logic [1:0]         r_cnt;
  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]   r_tags [NUM_LINES];
  logic [31:0]        r_data [NUM_LINES*4];
  logic [31:0]        r_hit_count;
  logic [31:0]        r_miss_count;

  logic [IDX_W-1:0]   w_idx;
  logic [TAG_W-1:0]   w_tag;
  logic [1:0]         w_off;
  logic               w_hit;
  logic               w_read;
  logic [IDX_W-1:0]   w_ridx;
  logic [TAG_W-1:0]   w_rtag;
  logic               w_wr_hit;
  logic               w_fill;

  assign w_idx  = cpu_addr[4 +: IDX_W];
  assign w_tag  = cpu_addr[31 -: TAG_W];
  assign w_off  = cpu_addr[3:2];
  assign w_hit  = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
  assign w_read = cpu_read && !cpu_write;

  // The registered request address drives every memory-side decision.
  assign w_ridx   = r_addr[4 +: IDX_W];
  assign w_rtag   = r_addr[31 -: TAG_W];
  assign w_wr_hit = r_valid[w_ridx] && (r_tags[w_ridx] == w_rtag);
  assign w_fill   = (r_state == REFILL) && mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (cpu_write)                w_next = WRITE;
        else if (cpu_read && !w_hit)  w_next = REFILL;
      end
      REFILL: if (mem_ready && (r_cnt == 2'd3)) w_next = IDLE;
      WRITE:  if (mem_ready)                    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    stall     = 1'b0;
    cpu_rdata = 32'h0;
    unique case (r_state)
      IDLE: begin
        if (cpu_write) begin
          stall = 1'b1;
        end else if (cpu_read) begin
          if (w_hit) cpu_rdata = r_data[{w_idx, w_off}];
          else       stall     = 1'b1;
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {r_addr[31:4], r_cnt, 2'b00};
        stall    = 1'b1;
      end
      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = r_addr & 32'hFFFF_FFFC;
        mem_wdata = r_wdata;
        stall     = !mem_ready;
      end
      default: ;
    endcase
  end

  // A line being refilled stays invalid until its last word lands, so an
  // aborted refill can never produce a false hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= 32'h0;
      r_wdata      <= 32'h0;
      r_cnt        <= 2'd0;
      r_valid      <= '0;
      r_hit_count  <= 32'h0;
      r_miss_count <= 32'h0;
    end else begin
      if (r_state == IDLE) begin
        r_cnt <= 2'd0;
        if (cpu_read || cpu_write) begin
          r_addr  <= cpu_addr;
          r_wdata <= cpu_wdata;
        end
        if (w_read && w_hit) r_hit_count <= r_hit_count + 32'd1;
        if (w_read && !w_hit) begin
          r_miss_count   <= r_miss_count + 32'd1;
          r_valid[w_idx] <= 1'b0;
        end
      end
      if (w_fill) begin
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) r_valid[w_ridx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_fill) begin
      r_data[{w_ridx, r_cnt}] <= mem_rdata;
      if (r_cnt == 2'd3) r_tags[w_ridx] <= w_rtag;
    end
    if ((r_state == WRITE) && mem_ready && w_wr_hit)
      r_data[{w_ridx, r_addr[3:2]}] <= r_wdata;
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: a wait-state memory responder plus a line-presence
// reference model that predicts stalls, load data and performance counters.
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_addr = 32'h0;
  logic [31:0] cpu_wdata = 32'h0;
  logic [31:0] cpu_rdata;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  always #5 clk = ~clk;

  dcache_ctrl #(.NUM_LINES(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  int          memWait = 0;
  logic [31:0] memModel [logic [31:0]];
  logic [31:0] rdAddrQ [$];
  int          memWrites = 0;
  logic        lastWe = 1'b0;
  logic [31:0] lastAddr = 32'h0;
  logic [31:0] lastWdata = 32'h0;

  bit          refValid [16];
  logic [23:0] refTag [16];
  logic [31:0] refHits = 32'h0;
  logic [31:0] refMisses = 32'h0;

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (memModel.exists(a)) return memModel[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void refReset();
    for (int i = 0; i < 16; i++) refValid[i] = 1'b0;
    refHits = 32'h0;
    refMisses = 32'h0;
  endfunction

  // Returns expected stall cycles; a miss also counts the hit of the held read.
  function automatic int refRead(input logic [31:0] addr, input int w);
    int idx;
    idx = int'(addr[7:4]);
    if (refValid[idx] && refTag[idx] == addr[31:8]) begin
      refHits++;
      return 0;
    end
    refMisses++;
    refHits++;
    refValid[idx] = 1'b1;
    refTag[idx] = addr[31:8];
    return 1 + 4 * (w + 1);
  endfunction

  // Memory: answers each request after memWait idle cycles, records transfers.
  initial begin
    int waitCnt;
    waitCnt = 0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready && rst_n) begin
        if (lastWe) begin
          memModel[lastAddr] = lastWdata;
          memWrites++;
        end else begin
          rdAddrQ.push_back(lastAddr);
        end
        waitCnt = 0;
      end
      if (mem_req && rst_n) begin
        if (waitCnt >= memWait) begin
          mem_ready = 1'b1;
          lastWe    = mem_we;
          lastAddr  = mem_addr;
          lastWdata = mem_wdata;
          mem_rdata = mem_we ? 32'h0 : memRead(mem_addr);
        end else begin
          mem_ready = 1'b0;
          waitCnt++;
        end
      end else begin
        mem_ready = 1'b0;
        waitCnt = 0;
      end
    end
  end

  task automatic doReset();
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    cpu_addr = 32'h0;
    cpu_wdata = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    refReset();
  endtask

  // Holds a request until stall drops; called and returns at posedge+2.
  task automatic cpuOp(input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, output int stalls,
                       output logic [31:0] rdata, output bit tmo,
                       output logic [31:0] hitsSeen);
    cpu_read = rd;
    cpu_write = wr;
    cpu_addr = addr;
    cpu_wdata = wdata;
    stalls = 0;
    tmo = 1'b0;
    rdata = 32'h0;
    hitsSeen = 32'h0;
    forever begin
      @(negedge clk);
      if (!stall) begin
        rdata = cpu_rdata;
        hitsSeen = hit_count;
        break;
      end
      stalls++;
      if (stalls > 300) begin
        tmo = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #2;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  function automatic bit lineAddrsBad(input logic [31:0] base);
    if (rdAddrQ.size() != 4) return 1'b1;
    for (int i = 0; i < 4; i++)
      if (rdAddrQ[i] !== base + 32'(4 * i)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_mem: req=%b we=%b addr=%h wdata=%h required all zero",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    checks++;
    if (stall !== 1'b0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_cpu: stall=%b rdata=%h required 0/0", stall, cpu_rdata);
    end
    checks++;
    if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_counters: hit=%0d miss=%0d required 0/0", hit_count, miss_count);
    end
    cpu_read = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_stall_with_request: got %b required 1", stall);
    end
    doReset();
  endtask

  task automatic test_read_miss();
    int s;
    logic [31:0] d;
    logic [31:0] hc;
    bit t;
    doReset();
    for (int i = 0; i < 4; i++) memModel[32'h40 + 32'(4 * i)] = 32'hA0 + 32'(i);
    memWait = 0;
    rdAddrQ.delete();
    void'(refRead(32'h40, 0));
    cpuOp(1'b1, 1'b0, 32'h40, 32'h0, s, d, t, hc);
    checks++;
    if (t || s != 5) begin
      errors++;
      $display("[TB] FAIL miss_stall: got %0d cycles (timeout=%b) required 5", s, t);
    end
    checks++;
    if (lineAddrsBad(32'h40)) begin
      errors++;
      $display("[TB] FAIL miss_addrs: got %0d words first=%h required 0x40..0x4C",
               rdAddrQ.size(), rdAddrQ.size() > 0 ? rdAddrQ[0] : 32'hX);
    end
    checks++;
    if (d !== 32'hA0) begin
      errors++;
      $display("[TB] FAIL miss_data: got %h required 000000a0", d);
    end
    checks++;
    if (miss_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL miss_count: got %0d required 1", miss_count);
    end
    void'(refRead(32'h48, 0));
    cpuOp(1'b1, 1'b0, 32'h48, 32'h0, s, d, t, hc);
    checks++;
    if (t || s != 0 || d !== 32'hA2) begin
      errors++;
      $display("[TB] FAIL hit_0x48: stall=%0d data=%h required 0/000000a2", s, d);
    end
    checks++;
    if (hc !== 32'd1) begin
      errors++;
      $display("[TB] FAIL hit_count: got %0d required 1", hc);
    end
  endtask

  task automatic test_write_hit();
    int s;
    int wb;
    logic [31:0] d;
    logic [31:0] hc;
    bit t;
    memWait = 2;
    wb = memWrites;
    cpuOp(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, s, d, t, hc);
    checks++;
    if (t || s != 3) begin
      errors++;
      $display("[TB] FAIL write_hit_stall: got %0d required 3", s);
    end
    checks++;
    if (memWrites != wb + 1 || lastWe !== 1'b1 || lastAddr !== 32'h44 || lastWdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL write_hit_bus: writes=%0d we=%b addr=%h wdata=%h required %0d/1/44/deadbeef",
               memWrites - wb, lastWe, lastAddr, lastWdata, 1);
    end
    memWait = 0;
    void'(refRead(32'h44, 0));
    cpuOp(1'b1, 1'b0, 32'h44, 32'h0, s, d, t, hc);
    checks++;
    if (t || s != 0 || d !== 32'hDEAD_BEEF) begin
      errors++;
      $display("[TB] FAIL write_hit_readback: stall=%0d data=%h required 0/deadbeef", s, d);
    end
  endtask

  task automatic test_write_miss();
    int s;
    int wb;
    int w;
    int exp;
    logic [31:0] d;
    logic [31:0] hc;
    logic [31:0] mb;
    logic [31:0] wd;
    bit t;
    w = $urandom_range(0, 3);
    memWait = w;
    wb = memWrites;
    mb = miss_count;
    wd = $urandom;
    cpuOp(1'b0, 1'b1, 32'h1000, wd, s, d, t, hc);
    checks++;
    if (t || s != 1 + w || memWrites != wb + 1 || miss_count !== mb) begin
      errors++;
      $display("[TB] FAIL write_miss: stall=%0d writes=%0d miss=%0d required %0d/1/%0d",
               s, memWrites - wb, miss_count, 1 + w, mb);
    end
    exp = refRead(32'h1000, w);
    cpuOp(1'b1, 1'b0, 32'h1000, 32'h0, s, d, t, hc);
    checks++;
    if (t || s != exp || d !== wd || miss_count !== mb + 32'd1) begin
      errors++;
      $display("[TB] FAIL write_miss_no_alloc: stall=%0d data=%h miss=%0d required %0d/%h/%0d",
               s, d, miss_count, exp, wd, mb + 32'd1);
    end
  endtask

  task automatic test_conflict();
    logic [31:0] addrs [3];
    int s;
    logic [31:0] d;
    logic [31:0] hc;
    bit t;
    addrs[0] = 32'h40;
    addrs[1] = 32'h140;
    addrs[2] = 32'h40;
    doReset();
    memWait = 0;
    for (int i = 0; i < 3; i++) begin
      void'(refRead(addrs[i], 0));
      cpuOp(1'b1, 1'b0, addrs[i], 32'h0, s, d, t, hc);
      checks++;
      if (t || s != 5 || d !== memRead(addrs[i])) begin
        errors++;
        $display("[TB] FAIL conflict_%0d: stall=%0d data=%h required 5/%h", i, s, d, memRead(addrs[i]));
      end
    end
    checks++;
    if (miss_count !== 32'd3) begin
      errors++;
      $display("[TB] FAIL conflict_misses: got %0d required 3", miss_count);
    end
  endtask

  task automatic test_reset_mid_refill();
    int n;
    int s;
    logic [31:0] d;
    logic [31:0] hc;
    bit t;
    memWait = 0;
    rdAddrQ.delete();
    cpu_read = 1'b1;
    cpu_addr = 32'h80;
    n = 0;
    while (rdAddrQ.size() < 2 && n < 50) begin
      @(posedge clk);
      #3;
      n++;
    end
    checks++;
    if (rdAddrQ.size() != 2) begin
      errors++;
      $display("[TB] FAIL midrefill_words: got %0d required 2", rdAddrQ.size());
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'h0 || cpu_rdata !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
      errors++;
      $display("[TB] FAIL midrefill_reset: req=%b addr=%h rdata=%h hit=%0d miss=%0d required all zero",
               mem_req, mem_addr, cpu_rdata, hit_count, miss_count);
    end
    cpu_read = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    refReset();
    rdAddrQ.delete();
    void'(refRead(32'h80, 0));
    cpuOp(1'b1, 1'b0, 32'h80, 32'h0, s, d, t, hc);
    checks++;
    if (t || s != 5 || lineAddrsBad(32'h80) || miss_count !== 32'd1 || d !== memRead(32'h80)) begin
      errors++;
      $display("[TB] FAIL midrefill_rerefill: stall=%0d words=%0d miss=%0d data=%h required 5/4/1/%h",
               s, rdAddrQ.size(), miss_count, d, memRead(32'h80));
    end
  endtask

  task automatic test_simultaneous();
    int s;
    int wb;
    logic [31:0] d;
    logic [31:0] hc;
    bit t;
    memWait = 1;
    wb = memWrites;
    cpuOp(1'b1, 1'b1, 32'h8C, 32'h5555_AAAA, s, d, t, hc);
    checks++;
    if (t || s != 2 || memWrites != wb + 1 || lastWe !== 1'b1 || lastAddr !== 32'h8C) begin
      errors++;
      $display("[TB] FAIL simultaneous: stall=%0d writes=%0d we=%b addr=%h required 2/1/1/0000008c",
               s, memWrites - wb, lastWe, lastAddr);
    end
    memWait = 0;
    void'(refRead(32'h8C, 0));
    cpuOp(1'b1, 1'b0, 32'h8C, 32'h0, s, d, t, hc);
    checks++;
    if (t || s != 0 || d !== 32'h5555_AAAA) begin
      errors++;
      $display("[TB] FAIL simultaneous_readback: stall=%0d data=%h required 0/5555aaaa", s, d);
    end
  endtask

  task automatic test_back_to_back();
    int s;
    logic [31:0] d;
    logic [31:0] hc;
    bit t;
    memWait = 0;
    rdAddrQ.delete();
    void'(refRead(32'h2A0, 0));
    cpuOp(1'b1, 1'b0, 32'h2A4, 32'h0, s, d, t, hc);
    checks++;
    if (t || s != 5 || lineAddrsBad(32'h2A0) || d !== memRead(32'h2A4)) begin
      errors++;
      $display("[TB] FAIL back_to_back: stall=%0d words=%0d data=%h required 5/4/%h",
               s, rdAddrQ.size(), d, memRead(32'h2A4));
    end
  endtask

  task automatic test_random();
    logic [23:0] tags [4];
    int op;
    int s;
    int exp;
    int wb;
    bit rd;
    bit wr;
    bit t;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] d;
    logic [31:0] hc;
    logic [31:0] expData;
    logic [31:0] hb;
    tags[0] = 24'h000000;
    tags[1] = 24'h000001;
    tags[2] = 24'h0A5A00;
    tags[3] = 24'hFFFFFF;
    for (int i = 0; i < 80; i++) begin
      op = $urandom_range(0, 3);
      memWait = $urandom_range(0, 3);
      addr = {tags[$urandom_range(0, 3)], 4'($urandom_range(0, 15)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      wd = $urandom;
      rd = (op != 2);
      wr = (op >= 2);
      wb = memWrites;
      hb = refHits;
      expData = memRead({addr[31:2], 2'b00});
      exp = wr ? 1 + memWait : refRead(addr, memWait);
      cpuOp(rd, wr, addr, wd, s, d, t, hc);
      checks++;
      if (t || s != exp) begin
        errors++;
        $display("[TB] FAIL rand_stall[%0d] addr=%h op=%0d: got %0d required %0d", i, addr, op, s, exp);
      end
      if (!wr) begin
        checks++;
        if (d !== expData || hc !== hb) begin
          errors++;
          $display("[TB] FAIL rand_read[%0d] addr=%h: data=%h hits_seen=%0d required %h/%0d",
                   i, addr, d, hc, expData, hb);
        end
      end
      checks++;
      if (hit_count !== refHits || miss_count !== refMisses || memWrites != wb + int'(wr)) begin
        errors++;
        $display("[TB] FAIL rand_counts[%0d]: hit=%0d miss=%0d writes=%0d required %0d/%0d/%0d",
                 i, hit_count, miss_count, memWrites - wb, refHits, refMisses, int'(wr));
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_write_hit();
    test_write_miss();
    test_conflict();
    test_reset_mid_refill();
    test_simultaneous();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Direct-mapped, write-through, no-write-allocate data cache between the execute stage and main memory. Load/store address comes straight from the ALU result. Read hits return data in the same cycle. Read misses refill a 4-word line from memory over a single-word handshake, and stores are written through to memory. The block stalls the pipeline while any memory transaction is outstanding.

## Interface
Parameters:
- `NUM_LINES`, default 16: number of cache lines. Must be a power of two, ≥2. `IDX_W = log2(NUM_LINES)`.
- Line size is fixed at 4 words of 32 bits.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpu_read` in 1: load request; held by the CPU while `stall` = 1.
- `cpu_write` in 1: store request; held by the CPU while `stall` = 1.
- `cpu_addr` in 32: byte address (ALU result). Bits [1:0] ignored.
- `cpu_wdata` in 32: store data.
- `cpu_rdata` out 32: load data.
- `stall` out 1: pipeline hold.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 = write, 0 = read.
- `mem_addr` out 32: word-aligned memory address.
- `mem_wdata` out 32: memory write data.
- `mem_rdata` in 32: memory read data, valid when `mem_ready` = 1.
- `mem_ready` in 1: transfer done.
- `hit_count` out 32: performance counter.
- `miss_count` out 32: performance counter.

## Operation
- **Address split:**
  - offset = `cpu_addr[3:2]`
  - index = `cpu_addr[4+IDX_W-1:4]`
  - tag = `cpu_addr[31:4+IDX_W]`
- **Storage:** per line, one valid bit, a tag and 4 data words.
- **Hit:** `valid[index]` = 1 and the stored tag equals the address tag.
- **Request priority:** if `cpu_write` and `cpu_read` are both 1, the request is treated as a write.
- **FSM states:** IDLE, REFILL, WRITE.
- **IDLE:**
  - Read hit: `cpu_rdata` = line word[offset] combinationally, `stall` = 0. `hit_count` increments.
  - Read miss: `stall` = 1, refill counter cleared, go to REFILL. `miss_count` increments.
  - Write (hit or miss): `stall` = 1, go to WRITE.
  - No request: `stall` = 0, `cpu_rdata` = 0.
- **REFILL:**
  - Outputs: `mem_req` = 1, `mem_we` = 0, `mem_addr` = {tag, index, cnt, 2'b00}, `stall` = 1.
  - On each edge with `mem_ready` = 1, `mem_rdata` is written to word[cnt] and cnt increments.
  - On the edge accepting word 3: tag written, valid set, go to IDLE. The held read then hits.
- **WRITE:**
  - Outputs: `mem_req` = 1, `mem_we` = 1, `mem_addr` = {`cpu_addr[31:2]`, 2'b00}, `mem_wdata` = `cpu_wdata`.
  - `stall` = !`mem_ready` (combinational).
  - On the `mem_ready` edge: if hit, the cached word[offset] is updated to `cpu_wdata`; on a miss, no allocation. Go to IDLE.
  - Write hits and write misses do not change the counters.
- **Memory handshake:**
  - `mem_req` stays high with `mem_addr`/`mem_we`/`mem_wdata` stable until `mem_ready`.
  - `mem_ready` is ignored when `mem_req` = 0.
  - Back-to-back refill words are allowed: `mem_req` stays high across words.
- **Counters:** 32-bit, wrap from 0xFFFFFFFF to 0.

## Timing
- **Reset (asynchronous):**
  - State IDLE, all valid bits 0, cnt 0, counters 0.
  - `mem_req` = 0, `mem_we` = 0, `mem_addr` = 0, `mem_wdata` = 0, `cpu_rdata` = 0.
  - `stall` = 0 unless a request is present.
  - Tag and data arrays need no reset.
- **Reset mid-REFILL:** aborts the refill. The line remains invalid, and the next access to it misses again.
- **Reset mid-WRITE:** aborts the write. Memory contents are undefined for that word; the cache line is unchanged.
- **Read hit:** 0 stall cycles.
- **Read miss** (memory answers in W wait cycles per word): stall cycles = 1 + 4·(W+1). With W = 0 this is 5.
- **Write** (W wait cycles): stall cycles = 1 + W. With W = 0 this is 1.
- **Outputs:** `mem_*` outputs are driven from the registered state and address. `stall` and `cpu_rdata` are combinational from the current state, the inputs and the arrays.

## Test plan
- **Reset then read miss:** read 0x0000_0040 after reset with memory returning 0xA0..0xA3 and W = 0.
  - Required: `stall` high 5 cycles; `mem_addr` 0x40, 0x44, 0x48, 0x4C; then `cpu_rdata` = 0xA0, `miss_count` = 1.
  - Follow-up: read 0x48 gives `cpu_rdata` = 0xA2 with 0 stall and `hit_count` = 1.
- **Write hit:** write 0xDEADBEEF to 0x44 after the fill, W = 2.
  - Required: `stall` 3 cycles; `mem_we` = 1, `mem_addr` = 0x44, `mem_wdata` = 0xDEADBEEF.
  - Follow-up: read 0x44 hits and returns 0xDEADBEEF.
- **Write miss:** write to 0x1000, followed by a read of 0x1000.
  - Required: the write causes one memory write and no allocation; the read then misses (`miss_count` increments).
- **Conflict eviction (`NUM_LINES` = 16):** read 0x40, then 0x140 (same index, different tag), then 0x40.
  - Required: three misses, `miss_count` = 3.
- **Reset mid-refill:** assert `rst_n` = 0 after 2 refill words.
  - Required: outputs take their reset values immediately; a later read of the same address misses and refills all 4 words.
- **Simultaneous request and back-to-back handshake:** `cpu_read` = `cpu_write` = 1.
  - Required: handled as a write (`mem_we` = 1).
  - With `mem_ready` held high throughout a refill: one word is accepted per cycle.
